median_filter_frame_ctrl: RTL and testbench
===========================================

// Module: median_filter_frame_ctrl
// PURPOSE
// - Sequences one frame through median_filter: on start_i, reads the frame buffer in raster order and drives the filter's pixel stream.
// - Sits between the frame-buffer read port and median_filter; counts filter outputs and waits for the filter's done.
// - Reports frame completion, or an error on output-count mismatch or drain timeout.
// PARAMETERS
// IMAGE_LEN      1080   pixels per line, forwarded to median_filter
// IMAGE_HEIGHT   720    lines per frame
// DRAIN_TIMEOUT  4096   max cycles in DRAIN before err_o
// PIXEL_W        24     packed pixel width {red,green,blue}
// PORTS
// clk           in   1        clock; only clock domain
// rst_n         in   1        synchronous reset, active low
// start_i       in   1        1-cycle pulse; starts a frame; ignored unless IDLE
// abort_i       in   1        cancels the frame; accepted in any state
// stall_i       in   1        source throttle; while high, no new read is issued
// mem_en_o      out  1        frame-buffer read enable
// mem_addr_o    out  AW       read address, AW=$clog2(IMAGE_LEN*IMAGE_HEIGHT)
// mem_data_i    in   PIXEL_W  read data, valid exactly 1 cycle after mem_en_o
// pix_o         if   master   pixel_valid_if to median_filter input
// filt_start_o  out  1        1-cycle start pulse to median_filter
// filt_valid_i  in   1        median_filter output valid, used for counting
// filt_done_i   in   1        median_filter done_o
// busy_o        out  1        high in any state other than IDLE
// frame_done_o  out  1        1-cycle pulse on successful frame completion
// err_o         out  1        sticky error flag; cleared by the next accepted start_i
// out_count_o   out  AW       filter outputs counted this frame
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge)
//   - All outputs go to 0: mem_en_o, mem_addr_o, pix_o.valid, filt_start_o, busy_o, frame_done_o, err_o, out_count_o.
//   - State goes to IDLE. A reset in mid-frame discards the frame and produces no pulses.
// - IDLE
//   - On start_i: filt_start_o=1 for one cycle; rd_addr=0, out_count=0, err cleared.
//   - Next state is STREAM.
// - STREAM
//   - Each cycle with stall_i=0: mem_en_o=1, mem_addr_o=rd_addr, then rd_addr++.
//   - With stall_i=1: mem_en_o=0 and the address holds.
//   - pix_o.valid is mem_en_o delayed 1 cycle. pix_o.pixel is mem_data_i unpacked with to_pixel mapping: [23:16]=red, [15:8]=green, [7:0]=blue.
//   - Gaps in pix_o.valid are legal; the filter advances only on valid.
//   - When the read of address IMAGE_LEN*IMAGE_HEIGHT-1 is issued, the next state is DRAIN. The final pix_o.valid is still emitted the cycle after.
// - DRAIN
//   - stall_i is don't-care. The timeout counter increments every cycle.
//   - On filt_done_i:
//     - If out_count == EXP=(IMAGE_LEN-1)*(IMAGE_HEIGHT-1), counting a filt_valid_i in that same cycle: frame_done_o=1 for one cycle.
//     - Otherwise: err_o=1.
//     - Either way, the next state is IDLE.
//   - If the timeout counter reaches DRAIN_TIMEOUT with no filt_done_i: err_o=1, next state IDLE, no frame_done_o.
// - out_count
//   - Increments on filt_valid_i while busy.
//   - Saturates at all-ones. If it would exceed EXP, err_o=1 immediately; the frame continues.
// - abort_i
//   - From any non-IDLE state, the next state is IDLE.
//   - mem_en_o is deasserted that cycle. A pix_o.valid pending from the prior read is suppressed.
//   - No frame_done_o, no err_o change.
//   - abort_i takes priority over start_i, filt_done_i and timeout in the same cycle.
// - start_i
//   - Ignored while busy_o=1.
//   - A start_i in the cycle frame_done_o/err_o is set (state still DRAIN) is ignored.
//   - A start_i on the first IDLE cycle is accepted.
// - Arithmetic
//   - rd_addr and out_count are unsigned AW bits. EXP is a localparam computed at elaboration.
//   - The timeout counter is $clog2(DRAIN_TIMEOUT+1) bits.
// - Latency
//   - start_i to first mem_en_o: 1 cycle.
//   - Stall-free frame: LEN*HEIGHT read cycles, then filter latency until done.
// STRUCTURE
// - median_filter_pkg gains ctrl_state_t enum {IDLE, STREAM, DRAIN}. pixel_t is reused from there.
// - Single module, no sub-modules.
// - Reuses the to_pixel helper for unpacking.
// - The testbench instantiates this block together with median_filter and a 1-cycle-latency bram model.
// TESTING (bench parameters LEN=4, HEIGHT=3, DRAIN_TIMEOUT=16)
// 1. Reset, then start_i with stall_i=0 and a done model firing after 6 outputs:
//    -> 12 reads, addresses 0..11 on consecutive cycles;
//    -> 12 pix_o.valid each 1 cycle after its read;
//    -> frame_done_o exactly once, out_count_o=6, err_o=0.
// 2. stall_i toggled every other cycle during STREAM -> addresses stay 0..11 with no skip or repeat; pixel data matches the memory; frame_done_o.
// 3. filt_done_i after only 5 outputs -> err_o=1, no frame_done_o, busy_o falls; the next start_i clears err_o.
// 4. filt_done_i held low -> err_o=1 exactly 16 cycles after entering DRAIN; state IDLE.
// 5. abort_i at address 5 -> mem_en_o=0 the next cycle, no further pix_o.valid, busy_o=0, no pulses; a following start_i restarts at address 0.
// 6. start_i pulsed mid-STREAM and in the done cycle -> ignored (no second filt_start_o); rst_n=0 mid-STREAM -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/median_filter_pkg.sv
// Shared types for the median filter datapath and its frame controller.
// Pixels travel packed as {red, green, blue}, 8 bits per channel.
package median_filter_pkg;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } ctrl_state_t;

    function automatic pixel_t to_pixel(input logic [23:0] d);
        pixel_t p;
        p.red   = d[23:16];
        p.green = d[15:8];
        p.blue  = d[7:0];
        return p;
    endfunction

endpackage

// File: rtl/pixel_valid_if.sv
// Pixel stream with a single valid qualifier; the consumer advances only on valid.
// There is no backpressure: a pixel is transferred in every cycle where valid is high.
interface pixel_valid_if;
    import median_filter_pkg::*;

    logic   valid;
    pixel_t pixel;

    modport master (output valid, output pixel);
    modport slave  (input  valid, input  pixel);
endinterface

// File: rtl/median_filter_frame_ctrl.sv
// Streams one frame from the frame buffer into median_filter in raster order,
// counts the filter's outputs and reports completion, count mismatch or drain timeout.
module median_filter_frame_ctrl
    import median_filter_pkg::*;
#(
    parameter int IMAGE_LEN     = 1080,
    parameter int IMAGE_HEIGHT  = 720,
    parameter int DRAIN_TIMEOUT = 4096,
    parameter int PIXEL_W       = 24,
    localparam int AW           = $clog2(IMAGE_LEN * IMAGE_HEIGHT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               stall_i,
    output logic               mem_en_o,
    output logic [AW-1:0]      mem_addr_o,
    input  logic [PIXEL_W-1:0] mem_data_i,
    pixel_valid_if.master      pix_o,
    output logic               filt_start_o,
    input  logic               filt_valid_i,
    input  logic               filt_done_i,
    output logic               busy_o,
    output logic               frame_done_o,
    output logic               err_o,
    output logic [AW-1:0]      out_count_o,
    output ctrl_state_t        state_o
);

    localparam int            NPIX      = IMAGE_LEN * IMAGE_HEIGHT;
    localparam int            TW        = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam logic [AW-1:0] EXP       = AW'((IMAGE_LEN - 1) * (IMAGE_HEIGHT - 1));
    localparam logic [TW-1:0] TMO_LAST  = TW'(DRAIN_TIMEOUT - 1);

    ctrl_state_t   r_state;
    ctrl_state_t   w_state_nxt;
    logic [AW-1:0] r_rd_addr;
    logic [AW-1:0] r_out_count;
    logic [AW-1:0] w_count_nxt;
    logic [TW-1:0] r_tmo;
    logic          r_pix_valid;
    logic          r_err;
    logic          r_frame_done;
    logic          r_filt_start;
    logic          w_busy;
    logic          w_accept;
    logic          w_mem_en;
    logic          w_overflow;
    logic          w_done_ok;
    logic          w_done_bad;
    logic          w_timeout;

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = (r_state != IDLE);
        w_accept    = (r_state == IDLE) && start_i;
        w_mem_en    = (r_state == STREAM) && !stall_i && !abort_i;
        w_count_nxt = r_out_count;
        w_overflow  = 1'b0;
        w_done_ok   = 1'b0;
        w_done_bad  = 1'b0;
        w_timeout   = 1'b0;

        // Saturating output count; reaching past EXP flags an error but the frame continues.
        if (w_busy && filt_valid_i) begin
            if (r_out_count != '1) begin
                w_count_nxt = r_out_count + AW'(1);
            end
            w_overflow = (r_out_count >= EXP);
        end

        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (abort_i) begin
                    w_state_nxt = IDLE;
                end else if (w_mem_en && (r_rd_addr == LAST_ADDR)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (abort_i) begin
                    w_state_nxt = IDLE;
                end else if (filt_done_i) begin
                    w_state_nxt = IDLE;
                    w_done_ok   = (w_count_nxt == EXP);
                    w_done_bad  = (w_count_nxt != EXP);
                end else if (r_tmo == TMO_LAST) begin
                    w_state_nxt = IDLE;
                    w_timeout   = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rd_addr    <= '0;
            r_out_count  <= '0;
            r_tmo        <= '0;
            r_pix_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_frame_done <= 1'b0;
            r_filt_start <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_filt_start <= w_accept;
            r_frame_done <= w_done_ok;
            r_pix_valid  <= w_mem_en;
            r_tmo        <= (r_state == DRAIN) ? r_tmo + TW'(1) : '0;
            if (w_accept) begin
                r_rd_addr   <= '0;
                r_out_count <= '0;
                r_err       <= 1'b0;
            end else begin
                if (w_mem_en) begin
                    r_rd_addr <= r_rd_addr + AW'(1);
                end
                r_out_count <= w_count_nxt;
                if (!abort_i && (w_overflow || w_done_bad || w_timeout)) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // An abort also hides the valid of the read issued in the previous cycle.
    assign pix_o.valid  = r_pix_valid && !abort_i;
    assign pix_o.pixel  = to_pixel(mem_data_i);
    assign mem_en_o     = w_mem_en;
    assign mem_addr_o   = w_mem_en ? r_rd_addr : '0;
    assign filt_start_o = r_filt_start;
    assign busy_o       = w_busy;
    assign frame_done_o = r_frame_done;
    assign err_o        = r_err;
    assign out_count_o  = r_out_count;
    assign state_o      = r_state;

endmodule

// File: tb/tb_median_filter_frame_ctrl.sv
// Directed bench for median_filter_frame_ctrl with a 1-cycle bram model and a
// scripted filter output/done model; read data is scoreboarded through pix_o.
module tb_median_filter_frame_ctrl;
    import median_filter_pkg::*;

    localparam int LEN  = 4;
    localparam int HGT  = 3;
    localparam int DT   = 16;
    localparam int NPIX = LEN * HGT;
    localparam int AW   = 4;
    localparam int EXP  = (LEN - 1) * (HGT - 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic          abort_i;
    logic          stall_i;
    logic          mem_en_o;
    logic [AW-1:0] mem_addr_o;
    logic [23:0]   mem_data_i;
    logic          filt_start_o;
    logic          filt_valid_i;
    logic          filt_done_i;
    logic          busy_o;
    logic          frame_done_o;
    logic          err_o;
    logic [AW-1:0] out_count_o;
    ctrl_state_t   state_o;

    pixel_valid_if u_pix ();

    median_filter_frame_ctrl #(
        .IMAGE_LEN     (LEN),
        .IMAGE_HEIGHT  (HGT),
        .DRAIN_TIMEOUT (DT),
        .PIXEL_W       (24)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .stall_i      (stall_i),
        .mem_en_o     (mem_en_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_i   (mem_data_i),
        .pix_o        (u_pix),
        .filt_start_o (filt_start_o),
        .filt_valid_i (filt_valid_i),
        .filt_done_i  (filt_done_i),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .err_o        (err_o),
        .out_count_o  (out_count_o),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    logic [23:0] mem [16];
    always @(posedge clk) begin
        if (mem_en_o) mem_data_i <= mem[mem_addr_o];
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [23:0] exp_q[$];
    int          cyc_q[$];
    int rd_exp, rd_cnt, pix_cnt, done_cnt, fs_cnt, stream_cycles;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Monitor: pops on pix_o.valid, pushes on each issued read.
    always @(negedge clk) begin
        logic [23:0] d;
        int          c;
        cyc++;
        if (u_pix.valid) begin
            pix_cnt++;
            chk("pix_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                d = exp_q.pop_front();
                c = cyc_q.pop_front();
                chk("pix_data", 32'({u_pix.pixel.red, u_pix.pixel.green, u_pix.pixel.blue}), 32'(d));
                chk("pix_latency", 32'(cyc), 32'(c + 1));
            end
        end
        if (mem_en_o) begin
            chk("rd_addr", 32'(mem_addr_o), 32'(rd_exp));
            exp_q.push_back(rd_exp < NPIX ? mem[rd_exp] : 24'h0);
            cyc_q.push_back(cyc);
            rd_exp++;
            rd_cnt++;
        end
        if (state_o == STREAM) stream_cycles++;
        if (frame_done_o) done_cnt++;
        if (filt_start_o) fs_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        rd_exp = 0; rd_cnt = 0; pix_cnt = 0; done_cnt = 0; fs_cnt = 0; stream_cycles = 0;
        exp_q.delete();
        cyc_q.delete();
    endtask

    task automatic start_frame();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic stream_to_drain(input bit toggle);
        int n = 0;
        while (state_o != DRAIN && n < 200) begin
            stall_i = toggle ? ~stall_i : 1'b0;
            tick();
            n++;
        end
        stall_i = 1'b0;
        chk("reach_drain", 32'(state_o), 32'(DRAIN));
    endtask

    task automatic emit(input int n, input bit start_on_done);
        for (int i = 0; i < n; i++) begin
            filt_valid_i = 1'b1;
            if (i == n - 1) begin
                filt_done_i = 1'b1;
                start_i     = start_on_done;
            end
            tick();
        end
        filt_valid_i = 1'b0;
        filt_done_i  = 1'b0;
        start_i      = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) mem[i] = 24'($urandom_range(0, 24'hFFFFFF));
        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; stall_i = 1'b0;
        filt_valid_i = 1'b0; filt_done_i = 1'b0;
        clear_counts();
        tick(); tick();

        chk("rst_mem_en", 32'(mem_en_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_count", 32'(out_count_o), 32'd0);
        chk("rst_state", 32'(state_o), 32'(IDLE));
        rst_n = 1'b1;
        tick();

        // Stall-free frame, done on the 6th output.
        clear_counts();
        start_frame();
        chk("t1_first_en", 32'(mem_en_o), 32'd1);
        chk("t1_first_addr", 32'(mem_addr_o), 32'd0);
        stream_to_drain(1'b0);
        emit(EXP, 1'b0);
        chk("t1_frame_done", 32'(frame_done_o), 32'd1);
        chk("t1_out_count", 32'(out_count_o), 32'(EXP));
        chk("t1_err", 32'(err_o), 32'd0);
        chk("t1_busy", 32'(busy_o), 32'd0);
        tick();
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_fs_cnt", 32'(fs_cnt), 32'd1);
        chk("t1_reads", 32'(rd_cnt), 32'(NPIX));
        chk("t1_pix", 32'(pix_cnt), 32'(NPIX));
        chk("t1_stream_cycles", 32'(stream_cycles), 32'(NPIX));
        chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // Alternate stall cycles.
        clear_counts();
        start_frame();
        stream_to_drain(1'b1);
        emit(EXP, 1'b0);
        tick();
        chk("t2_done_cnt", 32'(done_cnt), 32'd1);
        chk("t2_reads", 32'(rd_cnt), 32'(NPIX));
        chk("t2_pix", 32'(pix_cnt), 32'(NPIX));
        chk("t2_stream_cycles", 32'(stream_cycles), 32'(2 * NPIX));
        chk("t2_err", 32'(err_o), 32'd0);

        // Short output count.
        clear_counts();
        start_frame();
        stream_to_drain(1'b0);
        emit(EXP - 1, 1'b0);
        chk("t3_err", 32'(err_o), 32'd1);
        chk("t3_busy", 32'(busy_o), 32'd0);
        tick();
        chk("t3_done_cnt", 32'(done_cnt), 32'd0);

        // Restart clears the error; then let DRAIN time out.
        clear_counts();
        start_frame();
        chk("t3_err_cleared", 32'(err_o), 32'd0);
        stream_to_drain(1'b0);
        n = 0;
        while (!err_o && n < 64) begin
            tick();
            n++;
        end
        chk("t4_timeout_cycles", 32'(n), 32'(DT));
        chk("t4_state", 32'(state_o), 32'(IDLE));
        chk("t4_busy", 32'(busy_o), 32'd0);
        tick();
        chk("t4_done_cnt", 32'(done_cnt), 32'd0);

        // Abort right after the read of address 5.
        clear_counts();
        start_frame();
        n = 0;
        while (!(mem_en_o && mem_addr_o == 4'd5) && n < 50) begin
            tick();
            n++;
        end
        chk("t5_reach_addr5", 32'(mem_addr_o), 32'd5);
        tick();
        abort_i = 1'b1;
        #1;
        chk("t5_abort_en", 32'(mem_en_o), 32'd0);
        chk("t5_abort_pix", 32'(u_pix.valid), 32'd0);
        tick();
        abort_i = 1'b0;
        chk("t5_busy", 32'(busy_o), 32'd0);
        repeat (4) tick();
        chk("t5_reads", 32'(rd_cnt), 32'd6);
        chk("t5_pix", 32'(pix_cnt), 32'd5);
        chk("t5_done_cnt", 32'(done_cnt), 32'd0);
        chk("t5_err", 32'(err_o), 32'd0);
        chk("t5_fs_cnt", 32'(fs_cnt), 32'd1);

        // Restart at address 0; stray starts mid-STREAM and in the done cycle.
        clear_counts();
        start_frame();
        chk("t5_restart_en", 32'(mem_en_o), 32'd1);
        chk("t5_restart_addr", 32'(mem_addr_o), 32'd0);
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        stream_to_drain(1'b0);
        emit(EXP, 1'b1);
        chk("t6_idle_after_done", 32'(state_o), 32'(IDLE));
        tick(); tick();
        chk("t6_fs_cnt", 32'(fs_cnt), 32'd1);
        chk("t6_done_cnt", 32'(done_cnt), 32'd1);
        chk("t6_reads", 32'(rd_cnt), 32'(NPIX));
        chk("t6_busy", 32'(busy_o), 32'd0);

        // Reset in mid-STREAM.
        clear_counts();
        start_frame();
        filt_valid_i = 1'b1;
        repeat (3) tick();
        filt_valid_i = 1'b0;
        chk("t6_pre_rst_count", 32'(out_count_o), 32'd3);
        rst_n = 1'b0;
        tick();
        chk("t6_rst_en", 32'(mem_en_o), 32'd0);
        chk("t6_rst_addr", 32'(mem_addr_o), 32'd0);
        chk("t6_rst_pix", 32'(u_pix.valid), 32'd0);
        chk("t6_rst_fs", 32'(filt_start_o), 32'd0);
        chk("t6_rst_busy", 32'(busy_o), 32'd0);
        chk("t6_rst_done", 32'(frame_done_o), 32'd0);
        chk("t6_rst_err", 32'(err_o), 32'd0);
        chk("t6_rst_count", 32'(out_count_o), 32'd0);
        rst_n = 1'b1;
        tick(); tick();
        chk("t6_rst_done_cnt", 32'(done_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
